branch_unit: RTL

//  Consumer end of the ALU status interface: holds the status register {V,N,Z}

---
 rtl/branch_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - branch unit: status register, PC/LR and a 3-state branch FSM
module branch_unit #(
    parameter int                PC_W     = 9,
    parameter logic [PC_W-1:0]   RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      z_in,
    input  logic            load_s,
    input  logic            inc_pc,
    input  logic            br_valid,
    input  logic [2:0]      br_cond,
    input  logic            br_link,
    input  logic [7:0]      br_imm,
    output logic            ready,
    output logic            done,
    output logic            taken,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] lr,
    output logic [2:0]      status
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EVAL   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [2:0]      r_cond;
    logic            r_link;
    logic [7:0]      r_imm;
    logic [PC_W-1:0] r_base;
    logic            r_decision;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_lr;
    logic [2:0]      r_status;
    logic            r_taken;
    logic            r_done;

    logic            w_accept;
    logic            w_cond_met;
    logic            w_lt;
    logic [PC_W-1:0] w_offset;
    logic [PC_W-1:0] w_target;

    assign w_accept = (r_state == S_IDLE) && br_valid;
    assign w_lt     = r_status[1] ^ r_status[2];

    // Sign-extending cast of the 8-bit word offset to PC width; sums wrap.
    assign w_offset = PC_W'($signed(r_imm));
    assign w_target = r_base + w_offset;

    always_comb begin
        w_cond_met = 1'b0;
        case (r_cond)
            3'b000:  w_cond_met = 1'b1;
            3'b001:  w_cond_met = r_status[0];
            3'b010:  w_cond_met = ~r_status[0];
            3'b011:  w_cond_met = w_lt;
            3'b100:  w_cond_met = w_lt | r_status[0];
            default: w_cond_met = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (br_valid) w_next = S_EVAL;
            S_EVAL:   w_next = S_COMMIT;
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Status is sampled by EVAL in its own cycle, so a load on the accept
    // edge is seen and a load during EVAL/COMMIT only affects later branches.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cond     <= 3'b000;
            r_link     <= 1'b0;
            r_imm      <= 8'h00;
            r_base     <= '0;
            r_decision <= 1'b0;
            r_pc       <= RESET_PC;
            r_lr       <= '0;
            r_status   <= 3'b000;
            r_taken    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (load_s) begin
                r_status <= z_in;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cond <= br_cond;
                        r_link <= br_link;
                        r_imm  <= br_imm;
                        r_base <= r_pc + PC_W'(1);
                    end else if (inc_pc) begin
                        r_pc <= r_pc + PC_W'(1);
                    end
                end
                S_EVAL: begin
                    r_decision <= w_cond_met;
                end
                S_COMMIT: begin
                    r_pc    <= r_decision ? w_target : r_base;
                    if (r_decision && r_link) begin
                        r_lr <= r_base;
                    end
                    r_taken <= r_decision;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign ready  = (r_state == S_IDLE);
    assign done   = r_done;
    assign taken  = r_taken;
    assign pc     = r_pc;
    assign lr     = r_lr;
    assign status = r_status;

endmodule
